// File: rtl/charge_pkg.sv
// Shared definitions for the multi-bay charging timer: bay states, coin values, helpers.
// Latency: none, types and pure functions only.
// Backpressure: not applicable.
package charge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHARGE = 2'd2,
    ST_DONE   = 2'd3
  } bay_state_e;

  localparam logic [3:0] COIN5  = 4'd5;
  localparam logic [3:0] COIN10 = 4'd10;

  // Paid credit to charging minutes, doubled once the bonus threshold is reached.
  function automatic int credit_to_min(input int credit, input int min_per_unit,
                                       input int bonus_thresh);
    int mins;
    mins = credit * min_per_unit;
    if (credit >= bonus_thresh) mins = mins * 2;
    return mins;
  endfunction

  // Binary 0..99 to two BCD digits {tens, ones} by repeated subtraction.
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [6:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 12; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, 4'(rem)};
  endfunction

endpackage

// File: rtl/charge_timer_multi_if.sv
// Operator-side bus of the charging timer: selection, coin/start/cancel pulses, status and display.
// Latency: wires only.
// Backpressure: none, every pulse is a single-cycle event with no handshake.
interface charge_timer_multi_if #(
  parameter int NCH        = 4,
  parameter int CREDIT_MAX = 20
);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(CREDIT_MAX + 1);

  logic [SW-1:0]  ch_sel;
  logic           m5;
  logic           m10;
  logic           start;
  logic           cancel;
  logic           coin_rej;
  logic           refund_vld;
  logic [CW-1:0]  refund_amt;
  logic [NCH-1:0] charge_on;
  logic [NCH-1:0] done;
  logic [3:0]     money2;
  logic [3:0]     money1;
  logic [3:0]     min2;
  logic [3:0]     min1;

  modport master (
    output ch_sel, m5, m10, start, cancel,
    input  coin_rej, refund_vld, refund_amt, charge_on, done, money2, money1, min2, min1
  );

  modport slave (
    input  ch_sel, m5, m10, start, cancel,
    output coin_rej, refund_vld, refund_amt, charge_on, done, money2, money1, min2, min1
  );

endinterface

// File: rtl/charge_bay.sv
// One charging bay: collects credit, converts it to minutes, counts down and holds DONE.
// Latency: state/credit/minutes update on the edge that samples the pulse; events are combinational.
// Backpressure: none; coins that cannot be accepted are flagged for rejection instead of stalling.
module charge_bay
  import charge_pkg::*;
#(
  parameter int CREDIT_MAX   = 20,
  parameter int MIN_PER_UNIT = 1,
  parameter int BONUS_THRESH = 15,
  parameter int DONE_HOLD    = 3,
  parameter int CW           = $clog2(CREDIT_MAX + 1),
  parameter int MW           = $clog2(2 * CREDIT_MAX * MIN_PER_UNIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic          m5,
  input  logic          m10,
  input  logic          start,
  input  logic          cancel,
  input  logic          tick,
  output bay_state_e    state_o,
  output logic [CW-1:0] credit_o,
  output logic [MW-1:0] minutes_o,
  output logic          coin_rej_o,
  output logic          refund_o
);

  localparam int HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  bay_state_e    state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [MW-1:0] minutes_q, minutes_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [3:0] coin_amt;
  logic       coin_hit;
  logic [7:0] coin_sum;
  logic       coin_fits;
  logic       rej_ev;
  logic       refund_ev;

  // Next-state logic; a coin arriving with start or cancel, or outside IDLE/LOAD, is handed back.
  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    minutes_d = minutes_q;
    hold_d    = hold_q;
    rej_ev    = 1'b0;
    refund_ev = 1'b0;

    // m5 and m10 together form one 15-unit coin, judged as a whole.
    coin_amt  = (m5 ? COIN5 : 4'd0) + (m10 ? COIN10 : 4'd0);
    coin_hit  = sel && (m5 || m10);
    coin_sum  = 8'(credit_q) + {4'd0, coin_amt};
    coin_fits = (coin_sum <= 8'(CREDIT_MAX));

    case (state_q)
      ST_IDLE: begin
        if (coin_hit) begin
          if (coin_fits) begin
            credit_d = CW'(coin_sum);
            state_d  = ST_LOAD;
          end else begin
            rej_ev = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (sel && cancel) begin
          refund_ev = 1'b1;
          rej_ev    = coin_hit;
          credit_d  = '0;
          state_d   = ST_IDLE;
        end else if (sel && start) begin
          // A tick in this same cycle is ignored: the full load wins.
          rej_ev    = coin_hit;
          minutes_d = MW'(credit_to_min(int'(credit_q), MIN_PER_UNIT, BONUS_THRESH));
          state_d   = ST_CHARGE;
        end else if (coin_hit) begin
          if (coin_fits) credit_d = CW'(coin_sum);
          else           rej_ev   = 1'b1;
        end
      end

      ST_CHARGE: begin
        rej_ev = coin_hit;
        if (sel && cancel) begin
          credit_d  = '0;
          minutes_d = '0;
          state_d   = ST_IDLE;
        end else if (tick) begin
          if (minutes_q <= MW'(1)) begin
            minutes_d = '0;
            hold_d    = '0;
            state_d   = ST_DONE;
          end else begin
            minutes_d = minutes_q - MW'(1);
          end
        end
      end

      ST_DONE: begin
        rej_ev = coin_hit;
        if (sel && cancel) begin
          credit_d = '0;
          hold_d   = '0;
          state_d  = ST_IDLE;
        end else if (tick) begin
          if (hold_q == HW'(DONE_HOLD - 1)) begin
            credit_d = '0;
            hold_d   = '0;
            state_d  = ST_IDLE;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bay state registers, cleared by reset with no refund.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      credit_q  <= '0;
      minutes_q <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      minutes_q <= minutes_d;
      hold_q    <= hold_d;
    end
  end

  assign state_o    = state_q;
  assign credit_o   = credit_q;
  assign minutes_o  = minutes_q;
  assign coin_rej_o = rej_ev;
  assign refund_o   = refund_ev;

endmodule

// File: rtl/charge_timer_multi.sv
// Multi-bay coin charging timer: shared minute prescaler, bay array, pulse outputs, BCD display mux.
// Latency: coin_rej/refund one cycle after the pulse; display is combinational from registered bay state.
// Backpressure: none; rejected coins are signalled on coin_rej rather than held off.
module charge_timer_multi
  import charge_pkg::*;
#(
  parameter int NCH           = 4,
  parameter int CREDIT_MAX    = 20,
  parameter int MIN_PER_UNIT  = 1,
  parameter int BONUS_THRESH  = 15,
  parameter int TICKS_PER_MIN = 60,
  parameter int DONE_HOLD     = 3
) (
  input  logic                clk,
  input  logic                rst,
  charge_timer_multi_if.slave bus
);

  localparam int CW = $clog2(CREDIT_MAX + 1);
  localparam int MW = $clog2(2 * CREDIT_MAX * MIN_PER_UNIT + 1);
  localparam int PW = $clog2(TICKS_PER_MIN);

  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("charge_timer_multi: NCH must be 1..8");
  end
  if (CREDIT_MAX > 99 || 2 * CREDIT_MAX * MIN_PER_UNIT > 99) begin : g_bad_bcd
    $error("charge_timer_multi: credit and minutes must fit in two BCD digits");
  end
  if (TICKS_PER_MIN < 2) begin : g_bad_tpm
    $error("charge_timer_multi: TICKS_PER_MIN must be at least 2");
  end
  if (DONE_HOLD < 1) begin : g_bad_hold
    $error("charge_timer_multi: DONE_HOLD must be at least 1");
  end

  logic [PW-1:0]  cnt_q, cnt_d;
  logic           tick;
  logic [NCH-1:0] sel_oh;

  bay_state_e     bay_state   [NCH];
  logic [CW-1:0]  bay_credit  [NCH];
  logic [MW-1:0]  bay_minutes [NCH];
  logic [NCH-1:0] bay_rej;
  logic [NCH-1:0] bay_refund;

  logic           coin_rej_q, coin_rej_d;
  logic           refund_vld_q, refund_vld_d;
  logic [CW-1:0]  refund_amt_q, refund_amt_d;

  bay_state_e     disp_state;
  logic [CW-1:0]  disp_credit;
  logic [MW-1:0]  disp_minutes;
  logic [7:0]     money_bcd;
  logic [7:0]     min_bcd;

  // Free-running minute prescaler; tick marks the last count of each minute.
  always_comb begin
    tick  = (cnt_q == PW'(TICKS_PER_MIN - 1));
    cnt_d = tick ? '0 : cnt_q + PW'(1);
  end

  // One-hot decode of ch_sel; out-of-range selections address no bay.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NCH; i++) sel_oh[i] = (int'(bus.ch_sel) == i);
  end

  for (genvar g = 0; g < NCH; g++) begin : g_bay
    charge_bay #(
      .CREDIT_MAX  (CREDIT_MAX),
      .MIN_PER_UNIT(MIN_PER_UNIT),
      .BONUS_THRESH(BONUS_THRESH),
      .DONE_HOLD   (DONE_HOLD),
      .CW          (CW),
      .MW          (MW)
    ) u_bay (
      .clk       (clk),
      .rst       (rst),
      .sel       (sel_oh[g]),
      .m5        (bus.m5),
      .m10       (bus.m10),
      .start     (bus.start),
      .cancel    (bus.cancel),
      .tick      (tick),
      .state_o   (bay_state[g]),
      .credit_o  (bay_credit[g]),
      .minutes_o (bay_minutes[g]),
      .coin_rej_o(bay_rej[g]),
      .refund_o  (bay_refund[g])
    );
  end

  // Pulse outputs: only the selected bay can raise an event, so OR-reduction is enough.
  always_comb begin
    coin_rej_d   = |bay_rej;
    refund_vld_d = |bay_refund;
    refund_amt_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bay_refund[i]) refund_amt_d = bay_credit[i];
    end
  end

  // Prescaler and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      coin_rej_q   <= 1'b0;
      refund_vld_q <= 1'b0;
      refund_amt_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      coin_rej_q   <= coin_rej_d;
      refund_vld_q <= refund_vld_d;
      refund_amt_q <= refund_amt_d;
    end
  end

  // Per-bay status straight from each bay's registered state.
  always_comb begin
    bus.charge_on = '0;
    bus.done      = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.charge_on[i] = (bay_state[i] == ST_CHARGE);
      bus.done[i]      = (bay_state[i] == ST_DONE);
    end
  end

  // Display mux: credit blanked in IDLE, minutes shown only while charging.
  always_comb begin
    disp_state   = ST_IDLE;
    disp_credit  = '0;
    disp_minutes = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_oh[i]) begin
        disp_state   = bay_state[i];
        disp_credit  = bay_credit[i];
        disp_minutes = bay_minutes[i];
      end
    end
    if (disp_state == ST_IDLE)   disp_credit  = '0;
    if (disp_state != ST_CHARGE) disp_minutes = '0;
    money_bcd = bin2bcd(7'(disp_credit));
    min_bcd   = bin2bcd(7'(disp_minutes));
  end

  assign bus.coin_rej   = coin_rej_q;
  assign bus.refund_vld = refund_vld_q;
  assign bus.refund_amt = refund_amt_q;
  assign bus.money2     = money_bcd[7:4];
  assign bus.money1     = money_bcd[3:0];
  assign bus.min2       = min_bcd[7:4];
  assign bus.min1       = min_bcd[3:0];

endmodule

// File: tb/tb_charge_timer_multi.sv
// Directed bench for charge_timer_multi with a pulse scoreboard for coin_rej/refund.
// Latency: pulses expected exactly one cycle after the driving pulse.
// Backpressure: not applicable.
module tb_charge_timer_multi;

  localparam int NCH        = 4;
  localparam int CREDIT_MAX = 20;
  localparam int TPM        = 4;
  localparam int DONE_HOLD  = 3;

  logic clk = 1'b0;
  logic rst;

  charge_timer_multi_if #(.NCH(NCH), .CREDIT_MAX(CREDIT_MAX)) bus ();

  charge_timer_multi #(
    .NCH          (NCH),
    .CREDIT_MAX   (CREDIT_MAX),
    .MIN_PER_UNIT (1),
    .BONUS_THRESH (15),
    .TICKS_PER_MIN(TPM),
    .DONE_HOLD    (DONE_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int due;
    bit rej;
    bit refv;
    int amt;
  } pulse_t;

  pulse_t pq[$];
  int checks = 0;
  int errors = 0;
  int cur    = 0;
  int tb_cnt = 0;
  int ticks  = 0;
  int model_credit[NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: advance the prescaler model and settle due pulses against the DUT.
  task automatic cyc();
    bit     was_rst;
    bit     rej_e;
    bit     ref_e;
    int     amt_e;
    pulse_t e;
    was_rst = rst;
    @(posedge clk);
    #1;
    cur++;
    if (was_rst) tb_cnt = 0;
    else if (tb_cnt == TPM - 1) begin
      tb_cnt = 0;
      ticks++;
    end else tb_cnt++;
    rej_e = 1'b0;
    ref_e = 1'b0;
    amt_e = 0;
    while (pq.size() > 0 && pq[0].due == cur) begin
      e = pq.pop_front();
      rej_e = rej_e | e.rej;
      if (e.refv) begin
        ref_e = 1'b1;
        amt_e = e.amt;
      end
    end
    chk("coin_rej", 32'(bus.coin_rej), 32'(rej_e));
    chk("refund_vld", 32'(bus.refund_vld), 32'(ref_e));
    if (ref_e) chk("refund_amt", 32'(bus.refund_amt), 32'(amt_e));
  endtask

  task automatic coin(input int bay, input bit a5, input bit a10);
    int amt;
    amt = (a5 ? 5 : 0) + (a10 ? 10 : 0);
    bus.ch_sel = 2'(bay);
    bus.m5     = a5;
    bus.m10    = a10;
    if (model_credit[bay] + amt > CREDIT_MAX)
      pq.push_back('{due: cur + 1, rej: 1'b1, refv: 1'b0, amt: 0});
    else
      model_credit[bay] += amt;
    cyc();
    bus.m5  = 1'b0;
    bus.m10 = 1'b0;
  endtask

  task automatic start_bay(input int bay);
    bus.ch_sel = 2'(bay);
    bus.start  = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic cancel_bay(input int bay, input bit refund);
    bus.ch_sel = 2'(bay);
    bus.cancel = 1'b1;
    if (refund) pq.push_back('{due: cur + 1, rej: 1'b0, refv: 1'b1, amt: model_credit[bay]});
    model_credit[bay] = 0;
    cyc();
    bus.cancel = 1'b0;
  endtask

  task automatic disp(input int bay, input int ec, input int em);
    bus.ch_sel = 2'(bay);
    #1;
    chk($sformatf("money2_b%0d", bay), 32'(bus.money2), 32'(ec / 10));
    chk($sformatf("money1_b%0d", bay), 32'(bus.money1), 32'(ec % 10));
    chk($sformatf("min2_b%0d", bay), 32'(bus.min2), 32'(em / 10));
    chk($sformatf("min1_b%0d", bay), 32'(bus.min1), 32'(em % 10));
  endtask

  task automatic run_ticks(input int n);
    int target;
    target = ticks + n;
    while (ticks < target) cyc();
  endtask

  task automatic align(input int c);
    while (tb_cnt != c) cyc();
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) model_credit[i] = 0;
    rst        = 1'b1;
    bus.ch_sel = '0;
    bus.m5     = 1'b0;
    bus.m10    = 1'b0;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_charge_on", 32'(bus.charge_on), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_refund_amt", 32'(bus.refund_amt), 32'(0));
    disp(0, 0, 0);
    disp(3, 0, 0);
    rst = 1'b0;
    cyc();

    // Bay 0: 5 + 10 = 15 credit, bonus gives 30 minutes
    coin(0, 1'b1, 1'b0);
    coin(0, 1'b0, 1'b1);
    disp(0, 15, 0);
    start_bay(0);
    chk("b0_charge_on", 32'(bus.charge_on[0]), 32'(1));
    disp(0, 15, 30);
    run_ticks(29);
    chk("b0_on_min1", 32'(bus.charge_on[0]), 32'(1));
    disp(0, 15, 1);
    run_ticks(1);
    chk("b0_done", 32'(bus.done[0]), 32'(1));
    chk("b0_off", 32'(bus.charge_on[0]), 32'(0));
    disp(0, 15, 0);
    run_ticks(DONE_HOLD - 1);
    chk("b0_hold", 32'(bus.done[0]), 32'(1));
    run_ticks(1);
    chk("b0_idle", 32'(bus.done[0]), 32'(0));
    disp(0, 0, 0);
    model_credit[0] = 0;

    // Bay 1: fill to 20, fifth coin rejected, 40 minutes
    for (int k = 0; k < 4; k++) coin(1, 1'b1, 1'b0);
    disp(1, 20, 0);
    coin(1, 1'b1, 1'b0);
    cyc();
    disp(1, 20, 0);
    start_bay(1);
    disp(1, 20, 40);
    cancel_bay(1, 1'b0);
    chk("b1_cancel_chg", 32'(bus.charge_on[1]), 32'(0));
    disp(1, 0, 0);
    coin(1, 1'b0, 1'b1);
    coin(1, 1'b1, 1'b1);
    cyc();
    disp(1, 10, 0);
    cancel_bay(1, 1'b1);
    cyc();

    // Bay 2: refund then ignored start
    coin(2, 1'b0, 1'b1);
    cancel_bay(2, 1'b1);
    cyc();
    disp(2, 0, 0);
    start_bay(2);
    cyc();
    chk("b2_start_ignored", 32'(bus.charge_on[2]), 32'(0));
    disp(2, 0, 0);

    // Bays 0 and 3 count down independently
    coin(0, 1'b1, 1'b0);
    coin(3, 1'b0, 1'b1);
    align(0);
    start_bay(0);
    start_bay(3);
    run_ticks(2);
    disp(0, 5, 3);
    disp(3, 10, 8);
    run_ticks(3);
    chk("b0_done_first", 32'(bus.done[0]), 32'(1));
    chk("b3_still_on", 32'(bus.charge_on[3]), 32'(1));
    disp(3, 10, 5);
    run_ticks(4);
    chk("b0_back_idle", 32'(bus.done[0]), 32'(0));
    disp(3, 10, 1);
    run_ticks(1);
    chk("b3_done", 32'(bus.done), 32'(4'b1000));
    model_credit[0] = 0;
    cancel_bay(3, 1'b0);
    chk("b3_cancel_done", 32'(bus.done[3]), 32'(0));
    disp(3, 0, 0);

    // Bay 2: combined coin, start on a tick cycle
    coin(2, 1'b1, 1'b1);
    disp(2, 15, 0);
    align(TPM - 1);
    start_bay(2);
    disp(2, 15, 30);
    for (int k = 0; k < TPM - 1; k++) cyc();
    disp(2, 15, 30);
    cyc();
    disp(2, 15, 29);
    run_ticks(17);
    disp(2, 15, 12);

    // Reset while charging: everything clears with no refund
    rst = 1'b1;
    cyc();
    chk("mid_rst_charge_on", 32'(bus.charge_on), 32'(0));
    chk("mid_rst_done", 32'(bus.done), 32'(0));
    disp(2, 0, 0);
    rst = 1'b0;
    model_credit[2] = 0;
    cyc();
    cyc();
    chk("post_rst_charge_on", 32'(bus.charge_on), 32'(0));

    chk("pulse_queue_empty", 32'(pq.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
